// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states,
// the captured-request record and the iteration count.
package mdu_pkg;

    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_t;

    // Everything about an accepted operation that the sign fix needs later.
    typedef struct packed {
        op_t  op;
        logic sa;   // dividend / multiplicand was negative (signed ops only)
        logic sb;   // divisor / multiplier was negative (signed ops only)
        logic dz;   // divide with a zero divisor
    } req_t;

    function automatic logic op_is_div(input op_t o);
        return o == OP_DIV || o == OP_DIVU;
    endfunction

    function automatic logic op_is_signed(input op_t o);
        return o == OP_MULT || o == OP_DIV;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration of the shared shift datapath.
//   is_div   : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      : {upper, lower} working register
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient bits}
//   opnd     : multiplicand (multiply) or divisor (divide), unsigned
//   acc_next : register value after this iteration
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;      // carry-out of the add lands in the top bit
    logic [WIDTH:0]   shifted;  // remainder shifted left with next dividend bit
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        shifted = acc[2*WIDTH-1:WIDTH-1];
        ge      = shifted >= {1'b0, opnd};
        // When ge holds the true difference is below opnd, so W bits suffice.
        diff    = shifted[WIDTH-1:0] - opnd;
        acc_next = '0;
        if (is_div) begin
            if (ge)
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_next = {sum, acc[WIDTH-1:1]};
            else
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair.
// Operands are made unsigned at acceptance, iterated one bit per cycle, and
// the sign is restored in the FINISH cycle when HI/LO are written.
//   clk, reset        : clock, async active-high reset
//   start, op, a, b   : launch request (sampled only when idle)
//   hi_we, lo_we, wdata : MTHI/MTLO writes, honoured only when idle and no start
//   busy, done        : operation in flight / one-cycle completion pulse
//   div_by_zero       : valid with done
//   hi, lo            : architectural HI/LO
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITERATIONS);

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    req_t               req;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_cap;    // raw dividend, returned as HI on divide-by-zero

    logic accept, finish, mt_ok, last_iter;

    // Operand conditioning at acceptance
    op_t              op_in;
    logic             sa_in, sb_in;
    logic [WIDTH-1:0] a_abs, b_abs;

    always_comb begin
        op_in = op_t'(op);
        sa_in = op_is_signed(op_in) && a[WIDTH-1];
        sb_in = op_is_signed(op_in) && b[WIDTH-1];
        a_abs = sa_in ? -a : a;
        b_abs = sb_in ? -b : b;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)     state_nx = RUN;
            RUN:     if (last_iter) state_nx = FINISH;
            FINISH:                 state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = state != IDLE;
        accept    = state == IDLE && start;
        mt_ok     = state == IDLE && !start;
        finish    = state == FINISH;
        last_iter = cnt == CW'(ITERATIONS - 1);
    end

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_is_div(req.op)),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_nx)
    );

    // Sign fix / result selection, consumed in FINISH
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;

    always_comb begin
        prod   = acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_hi = '0;
        res_lo = '0;
        if (!op_is_div(req.op)) begin
            if (req.sa ^ req.sb) prod = -acc;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (req.dz) begin
            res_hi = a_cap;
            res_lo = '1;
        end else begin
            // sa/sb are only ever set for signed ops, so DIVU falls through.
            if (req.sa ^ req.sb) quo = -quo;
            if (req.sa)          rem = -rem;
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            req         <= '0;
            acc         <= '0;
            opnd        <= '0;
            a_cap       <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= finish;
            div_by_zero <= finish && req.dz;

            if (accept) begin
                req.op <= op_in;
                req.sa <= sa_in;
                req.sb <= sb_in;
                req.dz <= op_is_div(op_in) && b == '0;
                a_cap  <= a;
                cnt    <= '0;
                // Multiply iterates over the multiplier in the low half;
                // divide shifts the dividend out of the low half.
                acc    <= op_is_div(op_in) ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                opnd   <= op_is_div(op_in) ? b_abs : a_abs;
            end else if (state == RUN) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
            end

            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (mt_ok) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/div_by_zero are pushed
// when an operation is launched and popped by a monitor on each done pulse.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [1:0]  op = 0;
    logic [31:0] a = 0, b = 0, wdata = 0;
    logic        hi_we = 0, lo_we = 0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent reference model built on the simulator's arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [63:0] p;
        e.dz = 0;
        case (o)
            OP_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            OP_MULT: begin
                p = 64'($signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}));
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            default: begin
                if (y == 0) begin
                    e.hi = x; e.lo = 32'hFFFF_FFFF; e.dz = 1;
                end else if (o == OP_DIVU) begin
                    e.lo = x / y; e.hi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 0;
                end else begin
                    e.lo = 32'($signed(x) / $signed(y));
                    e.hi = 32'($signed(x) % $signed(y));
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected result.
    always @(posedge clk) begin
        #1;
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("dz", div_by_zero, e.dz);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    // Launch one op and wait for done. poke=1 fires a second start and an
    // MTHI/MTLO write in cycle 5, all of which must be ignored.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input exp_t e, input bit poke);
        int  k;
        bit  dz_early;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 0;
        chk("busy_after_start", busy, 1);
        dz_early = 0;
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
            if (div_by_zero) dz_early = 1;
            if (poke && k == 5) begin
                start = 1; op = OP_MULTU; a = 32'h1234; b = 32'h5678;
                hi_we = 1; lo_we = 1; wdata = 32'hDEAD_BEEF;
            end else if (poke && k == 6) begin
                start = 0; hi_we = 0; lo_we = 0;
            end
        end
        chk("latency", k, 33);
        chk("dz_outside_done", dz_early, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        repeat (2) @(negedge clk);
        reset = 0;

        e = '{32'hFFFF_FFFE, 32'h0000_0001, 1'b0}; run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, 0);
        e = '{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0}; run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7, e, 0);
        e = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}; run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, e, 0);
        e = '{32'h0000_0002, 32'h0000_000E, 1'b0}; run_op(OP_DIVU,  32'd100, 32'd7, e, 0);
        e = '{32'h0000_0000, 32'h8000_0000, 1'b0}; run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, e, 0);
        e = '{32'h1234_5678, 32'hFFFF_FFFF, 1'b1}; run_op(OP_DIV,   32'h1234_5678, 32'd0, e, 0);
        e = '{32'h0000_0000, 32'h0000_0006, 1'b0}; run_op(OP_MULTU, 32'd2, 32'd3, e, 1);

        // MTHI while idle, then MTLO
        @(negedge clk); hi_we = 1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1; hi_we = 0;
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_lo_kept", lo, 32'h6);
        @(negedge clk); lo_we = 1; wdata = 32'h0BAD_F00D;
        @(posedge clk); #1; lo_we = 0;
        chk("mtlo_lo", lo, 32'h0BAD_F00D);

        // Reset in cycle 10 of a DIVU
        @(negedge clk); start = 1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
        @(posedge clk); #1; start = 0;
        repeat (10) @(posedge clk);
        #1; reset = 1; #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        @(negedge clk); reset = 0;
        repeat (40) @(posedge clk);   // monitor flags any stray done
        #1;
        chk("post_rst_idle", busy, 0);

        e = '{32'd6, 32'd142, 1'b0}; run_op(OP_DIVU, 32'd1000, 32'd7, e, 0);

        // Random mix against the reference model
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = $urandom();
            y = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
            if (i % 2 == 1) y = -y;
            e = model(o, x, y);
            run_op(o, x, y, e, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
